octave_downsampler: RTL and testbench

OCTAVE_DOWNSAMPLER -- requirements
Module: octave_downsampler

---
 rtl/octave_downsampler.sv | 175 +++++++++++++++++
 tb/tb_octave_downsampler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/octave_downsampler.sv
`default_nettype none
// ============================================================================
//  Module      : octave_downsampler
//  Description : Takes the blurred pixel stream from the upstream Gaussian
//                stage, skips the filter latency, and writes every pixel whose
//                column and row are both even into a half-resolution frame
//                buffer. One frame is captured per start pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module octave_downsampler #(
    parameter int WIDTH  = 400,
    parameter int HEIGHT = 300,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        pix_in,
    input  logic              pix_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done
);

    // Filter latency in accepted samples before the first valid centre pixel.
    localparam int LAT     = 2 * WIDTH + 2;
    localparam int PRIME_W = (LAT > 1)    ? $clog2(LAT)    : 1;
    localparam int CX_W    = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int CY_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(LAT - 1);
    localparam logic [CX_W-1:0]    CX_LAST    = CX_W'(WIDTH - 1);
    localparam logic [CY_W-1:0]    CY_LAST    = CY_W'(HEIGHT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         state_q,   state_d;
    logic [PRIME_W-1:0] prime_q,   prime_d;
    logic [CX_W-1:0]    cx_q,      cx_d;
    logic [CY_W-1:0]    cy_q,      cy_d;
    logic [ADDR_W-1:0]  out_q,     out_d;
    logic               wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;

    logic prime_last;
    logic cx_last;
    logic cy_last;
    logic keep;

    assign prime_last = (prime_q == PRIME_LAST);
    assign cx_last    = (cx_q == CX_LAST);
    assign cy_last    = (cy_q == CY_LAST);
    // Top-left pixel of every 2x2 block survives decimation.
    assign keep       = ~cx_q[0] & ~cy_q[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                if (pix_en && prime_last) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (pix_en && cx_last && cy_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state_q == S_PRIME) || (state_q == S_ACTIVE);
        done = (state_q == S_DONE);
    end

    // Counter and write-port next values; the sample arriving with start is not counted.
    always_comb begin
        prime_d   = prime_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        out_d     = out_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    prime_d = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                    out_d   = '0;
                end
            end
            S_PRIME: begin
                if (pix_en && !prime_last) begin
                    prime_d = prime_q + PRIME_W'(1);
                end
            end
            S_ACTIVE: begin
                if (pix_en) begin
                    if (keep) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = out_q;
                        wr_data_d = pix_in;
                        out_d     = out_q + ADDR_W'(1);
                    end
                    if (cx_last) begin
                        cx_d = '0;
                        cy_d = cy_last ? '0 : cy_q + CY_W'(1);
                    end else begin
                        cx_d = cx_q + CX_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Counter and registered write-port storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_q   <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            out_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            prime_q   <= prime_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            out_q     <= out_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_octave_downsampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_octave_downsampler
//  Description : Directed bench for octave_downsampler (8x4 frame) with a
//                sample-count reference model and hand-computed write lists.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_octave_downsampler;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW  = 4;
    localparam int LAT = 2 * W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    pix_in;
    logic          pix_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;

    octave_downsampler #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pix_in  (pix_in),
        .pix_en  (pix_en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (sample counting) ----------------
    bit m_armed = 0;
    int m_k     = 0;
    bit e_wr    = 0;
    int e_addr  = 0;
    int e_data  = 0;
    bit e_done  = 0;

    always @(posedge clk) begin
        bit was_done;
        int c;
        int cx;
        int cy;
        if (rst) begin
            m_armed = 0; m_k = 0; e_wr = 0; e_addr = 0; e_data = 0; e_done = 0;
        end else begin
            was_done = e_done;
            e_wr   = 0;
            e_done = 0;
            if (m_armed) begin
                if (pix_en) begin
                    c = m_k - LAT;
                    if (c >= 0) begin
                        cx = c % W;
                        cy = c / W;
                        if ((cx % 2 == 0) && (cy % 2 == 0)) begin
                            e_wr   = 1;
                            e_addr = (cy / 2) * (W / 2) + cx / 2;
                            e_data = int'(pix_in);
                        end
                        if (c == W * H - 1) begin
                            m_armed = 0;
                            e_done  = 1;
                        end
                    end
                    m_k++;
                end
            end else if (!was_done && start) begin
                m_armed = 1;
                m_k     = 0;
            end
        end
    end

    // Per-cycle comparison against the model, just after each edge.
    always @(posedge clk) begin
        #1;
        check("wr_en", int'(wr_en), int'(e_wr));
        check("busy",  int'(busy),  int'(m_armed));
        check("done",  int'(done),  int'(e_done));
        if (e_wr) begin
            check("wr_addr", int'(wr_addr), e_addr);
            check("wr_data", int'(wr_data), e_data);
        end
        if (rst) begin
            check("rst_wr_addr", int'(wr_addr), 0);
            check("rst_wr_data", int'(wr_data), 0);
        end
    end

    // Write log and done counter for literal checks.
    int log_a[$];
    int log_d[$];
    int done_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            log_a.push_back(int'(wr_addr));
            log_d.push_back(int'(wr_data));
        end
        if (done) done_cnt++;
    end

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        done_cnt = 0;
    endtask

    task automatic tick(input bit st, input bit en, input int v);
        @(negedge clk);
        start  = st;
        pix_en = en;
        pix_in = 8'(v);
    endtask

    // Hand-derived writes for an 8x4 frame fed with pix_in = k + off.
    task automatic check_log(input string tag, input int off);
        int lit[8];
        lit = '{18, 20, 22, 24, 34, 36, 38, 40};
        check({tag, "_nwrites"}, log_a.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_a.size()) begin
                check({tag, "_addr"}, log_a[i], i);
                check({tag, "_data"}, log_d[i], lit[i] + off);
            end
        end
    endtask

    task automatic frame(input int off, input bit gaps, input int start_at);
        tick(1, 0, 0);
        for (int k = 0; k < 50; k++) begin
            tick(k == start_at, 1, k + off);
            if (gaps && k != 49) tick(0, 0, 8'hAA);
        end
    endtask

    initial begin
        rst = 1; start = 0; pix_en = 0; pix_in = 0;
        repeat (3) @(negedge clk);
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_busy",  int'(busy),  0);
        check("reset_done",  int'(done),  0);
        check("reset_addr",  int'(wr_addr), 0);
        rst = 0;
        repeat (2) tick(0, 0, 0);

        // Contiguous stream.
        clear_log();
        frame(0, 0, -1);
        @(posedge clk); #2;
        check("s1_done_after_49", int'(done), 1);
        check("s1_busy_falls",    int'(busy), 0);
        tick(0, 0, 0);
        @(posedge clk); #2;
        check("s1_done_one_cycle", int'(done), 0);
        check_log("s1", 0);
        check("s1_done_count", done_cnt, 1);

        // Same stream with idle cycles interleaved.
        clear_log();
        frame(0, 1, -1);
        repeat (3) tick(0, 0, 0);
        check_log("s2", 0);

        // Spurious start mid-frame at sample 30.
        clear_log();
        frame(0, 0, 30);
        repeat (3) tick(0, 0, 0);
        check_log("s3", 0);

        // Reset at sample 25, then restart with offset data.
        tick(1, 0, 0);
        for (int k = 0; k < 25; k++) tick(0, 1, k);
        @(negedge clk);
        rst = 1; start = 1; pix_en = 1; pix_in = 8'd25;
        @(negedge clk);
        rst = 0; start = 0;
        clear_log();
        for (int k = 0; k < 3; k++) tick(0, 1, 60 + k);
        check("s4_no_write_after_rst", log_a.size(), 0);
        check("s4_idle_busy", int'(busy), 0);
        frame(100, 0, -1);
        repeat (3) tick(0, 0, 0);
        check_log("s4", 100);

        // pix_en before and coincident with start must not be counted.
        for (int i = 0; i < 10; i++) tick(0, 1, 200 + i);
        clear_log();
        tick(1, 1, 99);
        for (int k = 0; k < 50; k++) tick(0, 1, k);
        repeat (3) tick(0, 0, 0);
        check_log("s5", 0);

        // Extra samples after done are ignored.
        clear_log();
        for (int i = 0; i < 20; i++) tick(0, 1, 150 + i);
        tick(0, 0, 0);
        check("s6_no_writes", log_a.size(), 0);
        check("s6_no_done",   done_cnt, 0);
        check("s6_busy",      int'(busy), 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
